// File: rtl/ad9866_pkg.sv
// Shared constants and FSM state type for the AD9866 Wishbone control master.
package ad9866_pkg;

    localparam int WB_ADR_W = 6;
    localparam int WB_DAT_W = 32;
    localparam int TIMER_W  = 10;
    localparam int ERRCNT_W = 8;

    localparam logic [WB_ADR_W-1:0] ADR_TXGAIN    = 6'h09;
    localparam logic [WB_ADR_W-1:0] ADR_RXGAIN    = 6'h0a;
    localparam logic [WB_ADR_W-1:0] ADR_AD9866_WR = 6'h3b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        GAP  = 2'd2
    } wbm_state_e;

endpackage

// File: rtl/sync_cmd_fifo.sv
// Single-clock showahead FIFO; full/empty come from wrap-bit pointers.
module sync_cmd_fifo #(
    parameter int WIDTH = 38,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             push, pop;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A push while full is refused even if a pop happens in the same cycle.
    assign push      = wr_en_i && !full_o;
    assign pop       = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/ad9866_wbm.sv
// Buffers decoded control writes and issues each as a Wishbone classic single write with ack timeout.
module ad9866_wbm
    import ad9866_pkg::*;
#(
    parameter int FIFO_AW       = 2,
    parameter int TIMEOUT       = 255,
    parameter int WB_ADDR_WIDTH = WB_ADR_W,
    parameter int WB_DATA_WIDTH = WB_DAT_W
) (
    input  logic                     clk_ad9866,
    input  logic                     rst_n,
    input  logic [WB_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [WB_DATA_WIDTH-1:0] cmd_data,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    output logic [WB_ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [WB_DATA_WIDTH-1:0] wbm_dat_o,
    output logic                     wbm_we_o,
    output logic                     wbm_stb_o,
    output logic                     wbm_cyc_o,
    input  logic                     wbm_ack_i,
    output logic                     busy,
    output logic                     timeout_pulse,
    output logic [ERRCNT_W-1:0]      timeout_cnt
);
    localparam int CMD_W = WB_ADDR_WIDTH + WB_DATA_WIDTH;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    wbm_state_e                state_q, state_d;
    logic [WB_ADDR_WIDTH-1:0]  adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0]  dat_q, dat_d;
    logic                      stb_q, stb_d;
    logic [TIMER_W-1:0]        timer_q, timer_d;
    logic                      pulse_q, pulse_d;
    logic [ERRCNT_W-1:0]       cnt_q, cnt_d;
    logic                      avail_q;

    logic                      fifo_full, fifo_empty, fifo_pop;
    logic [CMD_W-1:0]          fifo_head;

    sync_cmd_fifo #(
        .WIDTH (CMD_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk_ad9866),
        .rst_n     (rst_n),
        .wr_en_i   (cmd_valid),
        .wr_data_i ({cmd_addr, cmd_data}),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d  = state_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        stb_d    = stb_q;
        timer_d  = timer_q;
        pulse_d  = 1'b0;
        cnt_d    = cnt_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (avail_q) begin
                    fifo_pop = 1'b1;
                    {adr_d, dat_d} = fifo_head;
                    stb_d   = 1'b1;
                    timer_d = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                timer_d = timer_q + TIMER_W'(1);
                if (wbm_ack_i) begin
                    stb_d   = 1'b0;
                    state_d = GAP;
                end else if (timer_q == TIMER_LAST) begin
                    stb_d   = 1'b0;
                    pulse_d = 1'b1;
                    if (cnt_q != '1) cnt_d = cnt_q + ERRCNT_W'(1);
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // avail_q is a registered view of occupancy, giving the two-edge push-to-strobe latency.
    always_ff @(posedge clk_ad9866 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            stb_q   <= 1'b0;
            timer_q <= '0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
            avail_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            stb_q   <= stb_d;
            timer_q <= timer_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            avail_q <= !fifo_empty && !fifo_pop;
        end
    end

    // One register drives cyc, stb and we so they can never disagree.
    assign wbm_adr_o     = adr_q;
    assign wbm_dat_o     = dat_q;
    assign wbm_stb_o     = stb_q;
    assign wbm_cyc_o     = stb_q;
    assign wbm_we_o      = stb_q;
    assign cmd_ready     = !fifo_full;
    assign busy          = !fifo_empty || (state_q != IDLE);
    assign timeout_pulse = pulse_q;
    assign timeout_cnt   = cnt_q;

endmodule

// File: tb/tb_ad9866_wbm.sv
// Directed scoreboard bench for ad9866_wbm with a programmable-delay slave ack model.
module tb_ad9866_wbm;
    import ad9866_pkg::*;

    localparam int TIMEOUT = 8;

    typedef struct packed {
        logic [5:0]  adr;
        logic [31:0] dat;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_ack_i;
    logic        busy, timeout_pulse;
    logic [7:0]  timeout_cnt;

    always #5 clk = ~clk;

    ad9866_wbm #(
        .FIFO_AW       (2),
        .TIMEOUT       (TIMEOUT),
        .WB_ADDR_WIDTH (6),
        .WB_DATA_WIDTH (32)
    ) dut (
        .clk_ad9866    (clk),
        .rst_n         (rst_n),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .wbm_adr_o     (wbm_adr_o),
        .wbm_dat_o     (wbm_dat_o),
        .wbm_we_o      (wbm_we_o),
        .wbm_stb_o     (wbm_stb_o),
        .wbm_cyc_o     (wbm_cyc_o),
        .wbm_ack_i     (wbm_ack_i),
        .busy          (busy),
        .timeout_pulse (timeout_pulse),
        .timeout_cnt   (timeout_cnt)
    );

    // Slave model: acks once stb has been high for ack_delay cycles.
    logic ack_en    = 1'b0;
    int   ack_delay = 0;
    int   stb_cnt   = 0;
    always @(posedge clk) stb_cnt <= wbm_stb_o ? stb_cnt + 1 : 0;
    assign wbm_ack_i = ack_en && wbm_stb_o && (stb_cnt >= ack_delay);

    int   checks   = 0;
    int   failures = 0;
    cmd_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: compares each new bus cycle against the scoreboard and tracks strobe timing.
    int   rises = 0, pulses = 0, low_run = 0, high_run = 0, last_high_len = 0;
    bit   prev_stb = 1'b0, seen_any = 1'b0;
    cmd_t exp_cmd;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stb = 1'b0; low_run = 0; high_run = 0; seen_any = 1'b0;
        end else begin
            check("cyc_we_track_stb", {62'd0, wbm_cyc_o, wbm_we_o}, {62'd0, wbm_stb_o, wbm_stb_o});
            if (timeout_pulse) pulses++;
            if (wbm_stb_o) begin
                if (!prev_stb) begin
                    rises++;
                    check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
                    if (sb_q.size() != 0) begin
                        exp_cmd = sb_q.pop_front();
                        check("issue_adr", 64'(wbm_adr_o), 64'(exp_cmd.adr));
                        check("issue_dat", 64'(wbm_dat_o), 64'(exp_cmd.dat));
                    end
                    if (seen_any) check("gap_ge2", 64'(low_run >= 2), 64'd1);
                    seen_any = 1'b1;
                    high_run = 0;
                end
                high_run++;
            end else begin
                if (prev_stb) last_high_len = high_run;
                low_run = prev_stb ? 1 : low_run + 1;
            end
            prev_stb = wbm_stb_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] a, input logic [31:0] d, output bit acc);
        cmd_addr  = a;
        cmd_data  = d;
        cmd_valid = 1'b1;
        acc       = cmd_ready;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (acc) sb_q.push_back('{adr: a, dat: d});
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic wait_pulse(input string tag, input int budget);
        int n = 0;
        while (!timeout_pulse && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(timeout_pulse), 64'd1);
    endtask

    initial begin
        bit acc;
        int r0, p0;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
        #12;
        check("rst_stb", 64'(wbm_stb_o), 64'd0);
        check("rst_cyc_we", 64'({wbm_cyc_o, wbm_we_o}), 64'd0);
        check("rst_adr_dat", {26'd0, wbm_adr_o, wbm_dat_o}, 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pulse", 64'(timeout_pulse), 64'd0);
        check("rst_tcnt", 64'(timeout_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single write: strobe after edge N+2, ack one cycle later.
        ack_en = 1'b1; ack_delay = 1;
        push(ADR_RXGAIN, 32'h0000_0045, acc);
        check("single_accept", 64'(acc), 64'd1);
        check("single_stb_n", 64'(wbm_stb_o), 64'd0);
        tick();
        check("single_stb_n1", 64'(wbm_stb_o), 64'd0);
        tick();
        check("single_stb_n2", 64'(wbm_stb_o), 64'd1);
        check("single_adr", 64'(wbm_adr_o), 64'(ADR_RXGAIN));
        check("single_dat", 64'(wbm_dat_o), 64'h45);
        tick();
        check("single_stb_hold", 64'(wbm_stb_o), 64'd1);
        tick();
        check("single_stb_drop", 64'(wbm_stb_o), 64'd0);
        check("single_busy_gap", 64'(busy), 64'd1);
        check("single_adr_hold", 64'(wbm_adr_o), 64'(ADR_RXGAIN));
        tick();
        check("single_busy_clear", 64'(busy), 64'd0);
        check("single_tcnt", 64'(timeout_cnt), 64'd0);

        // Burst with backpressure: first command stalls on the bus while the FIFO fills.
        ack_en = 1'b0; ack_delay = 0;
        r0 = rises;
        push(ADR_TXGAIN, 32'hA000_0000, acc);
        for (int i = 0; i < 5; i++) begin
            push(6'(8'h10 + i), 32'hB000_0000 + 32'(i), acc);
            check($sformatf("burst_accept_%0d", i), 64'(acc), 64'(i < 4));
            if (i == 3) check("burst_ready_low", 64'(cmd_ready), 64'd0);
        end
        ack_en = 1'b1;
        wait_idle("burst_idle", 200);
        check("burst_issued", 64'(rises - r0), 64'd5);
        check("burst_sb_empty", 64'(sb_q.size()), 64'd0);
        check("burst_tcnt", 64'(timeout_cnt), 64'd0);

        // Timeout: no ack, strobe held exactly TIMEOUT cycles, queued command follows.
        ack_en = 1'b0;
        p0 = pulses;
        push(ADR_TXGAIN, 32'h0000_1234, acc);
        push(ADR_AD9866_WR, 32'h0000_0055, acc);
        wait_pulse("to_pulse_seen", 60);
        check("to_stb_low", 64'(wbm_stb_o), 64'd0);
        check("to_tcnt", 64'(timeout_cnt), 64'd1);
        ack_en = 1'b1;
        tick();
        check("to_pulse_one_cycle", 64'(timeout_pulse), 64'd0);
        check("to_stb_len", 64'(last_high_len), 64'(TIMEOUT));
        wait_idle("to_idle", 60);
        check("to_next_issued", 64'(sb_q.size()), 64'd0);
        check("to_pulse_count", 64'(pulses - p0), 64'd1);

        // Ack exactly on the timeout cycle wins; one cycle later it loses.
        ack_delay = TIMEOUT - 1;
        push(ADR_RXGAIN, 32'h0000_0077, acc);
        wait_idle("ackto_idle", 60);
        tick();
        check("ackto_tcnt", 64'(timeout_cnt), 64'd1);
        check("ackto_pulses", 64'(pulses - p0), 64'd1);
        check("ackto_len", 64'(last_high_len), 64'(TIMEOUT));
        ack_delay = TIMEOUT;
        push(ADR_RXGAIN, 32'h0000_0078, acc);
        wait_idle("late_idle", 60);
        tick();
        check("late_tcnt", 64'(timeout_cnt), 64'd2);
        check("late_len", 64'(last_high_len), 64'(TIMEOUT));

        // Saturation of the abandoned-cycle counter.
        ack_en = 1'b0;
        p0 = pulses;
        for (int i = 0; i < 260; i++) begin
            push(6'(i), 32'(i), acc);
            wait_pulse("sat_pulse", 40);
        end
        tick();
        wait_idle("sat_idle", 20);
        check("sat_tcnt", 64'(timeout_cnt), 64'd255);
        check("sat_pulses", 64'(pulses - p0), 64'd260);

        // Reset mid-cycle with three entries queued.
        for (int i = 0; i < 4; i++) push(6'(8'h20 + i), 32'hC000_0000 + 32'(i), acc);
        check("mid_stb_high", 64'(wbm_stb_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_stb_cyc_we", 64'({wbm_stb_o, wbm_cyc_o, wbm_we_o}), 64'd0);
        check("mid_rst_ready", 64'(cmd_ready), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_tcnt", 64'(timeout_cnt), 64'd0);
        sb_q.delete();
        r0 = rises;
        @(negedge clk);
        rst_n = 1'b1;
        ack_en = 1'b1; ack_delay = 0;
        repeat (20) tick();
        check("post_rst_no_issue", 64'(rises - r0), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
